// File: rtl/lht_pkg.sv
// Shared definitions for the local history table (LHT) update scheduler.
// Holds the default table geometry, the controller state encoding and the
// layout of a resolved-but-not-yet-written history update.
package lht_pkg;

    localparam int LHT_IDX_W  = 10;
    localparam int LHT_HIST_W = 10;

    // The table is cleared once after reset, and then the controller runs normally
    typedef enum logic {
        INIT,
        RUN
    } lht_state_t;

    // A resolved branch whose outcome still has to be shifted into its table entry
    typedef struct packed {
        logic [LHT_IDX_W-1:0] idx;
        logic                 taken;
    } lht_upd_t;

endpackage

// File: rtl/lht_inflight_fifo.sv
// In-flight branch FIFO: holds the table index of every fetched branch that
// has not resolved yet, oldest at the head.
// Ports:
//   clock, reset      clock and asynchronous active-low reset
//   push, push_data   enqueue an index (ignored when full unless also popping)
//   pop               dequeue the head
//   flush             empty the FIFO at the next edge (after any pop)
//   head              oldest entry (combinational)
//   full, empty       occupancy flags
//   count             number of valid entries
module lht_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH[PTR_W:0]);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush wins over any push/pop: whatever was popped this cycle is already
    // consumed by the caller, and the remainder is discarded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lht_update_scheduler.sv
// LHT controller: clears the table after reset, tracks in-flight branches,
// and shares the table's single combinational read port between predictor
// lookups and read-modify-write history updates from resolved branches.
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   br_valid/br_pc/br_ready      fetched branch enters the in-flight queue
//   res_valid/res_taken/res_ready oldest in-flight branch resolves
//   flush                        squash all unresolved in-flight branches
//   lk_valid/lk_pc/lk_hist/lk_stall predictor lookup; stalled when an update steals the port
//   tbl_raddr/tbl_rdata          LHT read port (combinational data)
//   tbl_we/tbl_waddr/tbl_wdata   LHT write port
//   init_done                    table clear finished
//   err                          sticky: a resolution arrived with nothing in flight
module lht_update_scheduler
    import lht_pkg::*;
#(
    parameter int IDX_W      = LHT_IDX_W,
    parameter int HIST_W     = LHT_HIST_W,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              br_valid,
    input  logic [31:0]       br_pc,
    output logic              br_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              res_ready,
    input  logic              flush,
    input  logic              lk_valid,
    input  logic [31:0]       lk_pc,
    output logic [HIST_W-1:0] lk_hist,
    output logic              lk_stall,
    output logic [IDX_W-1:0]  tbl_raddr,
    input  logic [HIST_W-1:0] tbl_rdata,
    output logic              tbl_we,
    output logic [IDX_W-1:0]  tbl_waddr,
    output logic [HIST_W-1:0] tbl_wdata,
    output logic              init_done,
    output logic              err
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    lht_state_t             state;
    lht_state_t             state_next;
    logic [IDX_W-1:0]       init_ptr;
    lht_upd_t               pend;
    logic                   pend_v;
    logic [CNT_W-1:0]       starve_cnt;
    logic                   err_q;

    logic [IDX_W-1:0]       lk_idx;
    logic [IDX_W-1:0]       fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(QDEPTH):0] fifo_count;
    logic                   run;
    logic                   upd_fire;
    logic                   steal;
    logic                   res_ok;
    logic                   res_fire;
    logic                   push;
    logic [HIST_W-1:0]      upd_hist;
    logic                   unused_bits;

    assign lk_idx = lk_pc[IDX_W-1:0];
    assign run    = (state == RUN);

    // A pending update may use the read port when no lookup wants it, when the
    // lookup targets the same entry (both are served by one read), or when it
    // has been blocked long enough to take the port from the lookup.
    assign upd_fire = run && pend_v &&
                      (!lk_valid || (lk_idx == pend.idx) || (starve_cnt == STARVE_LIM));
    assign steal    = upd_fire && lk_valid && (lk_idx != pend.idx);
    assign upd_hist = {pend.taken, tbl_rdata[HIST_W-1:1]};

    // Only one update can be held, so a new resolution is accepted only if the
    // pend slot is free or is being written this very cycle.
    assign res_ok   = run && !fifo_empty && (!pend_v || upd_fire);
    assign res_fire = res_valid && res_ok;
    assign push     = run && br_valid && !fifo_full;

    assign unused_bits = ^{br_pc[31:IDX_W], lk_pc[31:IDX_W], tbl_rdata[0], fifo_count};

    lht_inflight_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (br_pc[IDX_W-1:0]),
        .pop       (res_fire),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register and the clear pointer that walks the table during INIT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    // Leave INIT once the last table entry has been cleared
    always_comb begin
        state_next = state;
        if ((state == INIT) && (init_ptr == '1)) begin
            state_next = RUN;
        end
    end

    // Pending update slot, starvation counter and sticky error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend       <= '0;
            pend_v     <= 1'b0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            if (res_fire) begin
                pend.idx   <= fifo_head;
                pend.taken <= res_taken;
                pend_v     <= 1'b1;
            end else if (upd_fire) begin
                pend_v <= 1'b0;
            end
            if (upd_fire) begin
                starve_cnt <= '0;
            end else if (pend_v && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (res_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Port mux: everything is held at zero while reset is asserted, INIT owns
    // the write port, and RUN arbitrates the read port between lookup and update.
    always_comb begin
        tbl_raddr = '0;
        tbl_we    = 1'b0;
        tbl_waddr = '0;
        tbl_wdata = '0;
        lk_hist   = '0;
        lk_stall  = 1'b0;
        br_ready  = 1'b0;
        res_ready = 1'b0;
        init_done = 1'b0;
        if (reset) begin
            if (state == INIT) begin
                tbl_we    = 1'b1;
                tbl_waddr = init_ptr;
                lk_stall  = 1'b1;
            end else begin
                init_done = 1'b1;
                br_ready  = !fifo_full;
                res_ready = res_ok;
                tbl_raddr = upd_fire ? pend.idx : lk_idx;
                if (upd_fire) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = pend.idx;
                    tbl_wdata = upd_hist;
                end
                if (steal) begin
                    lk_stall = 1'b1;
                end else if (upd_fire && lk_valid) begin
                    lk_hist = upd_hist;
                end else begin
                    lk_hist = tbl_rdata;
                end
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_lht_update_scheduler.sv
// Bench for lht_update_scheduler: provides a behavioural LHT memory, drives
// directed and random traffic, and compares against a queue-based model of
// in-flight branches and per-entry histories.
module tb_lht_update_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic        br_ready;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        res_ready;
    logic        flush = 1'b0;
    logic        lk_valid = 1'b0;
    logic [31:0] lk_pc = '0;
    logic [9:0]  lk_hist;
    logic        lk_stall;
    logic [9:0]  tbl_raddr;
    logic [9:0]  tbl_rdata;
    logic        tbl_we;
    logic [9:0]  tbl_waddr;
    logic [9:0]  tbl_wdata;
    logic        init_done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [9:0] mem [1024];
    logic [9:0] ref_hist [1024];
    logic [9:0] ref_q [$];
    bit         ref_err = 1'b0;
    bit         tb_run = 1'b0;

    lht_update_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .br_valid  (br_valid),
        .br_pc     (br_pc),
        .br_ready  (br_ready),
        .res_valid (res_valid),
        .res_taken (res_taken),
        .res_ready (res_ready),
        .flush     (flush),
        .lk_valid  (lk_valid),
        .lk_pc     (lk_pc),
        .lk_hist   (lk_hist),
        .lk_stall  (lk_stall),
        .tbl_raddr (tbl_raddr),
        .tbl_rdata (tbl_rdata),
        .tbl_we    (tbl_we),
        .tbl_waddr (tbl_waddr),
        .tbl_wdata (tbl_wdata),
        .init_done (init_done),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Behavioural LHT storage: combinational read, write on the clock edge
    assign tbl_rdata = mem[tbl_raddr];
    always @(posedge clock) begin
        if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after the falling edge, checks the
    // model-level invariants, then advances the model as of the next rising edge.
    task automatic applyStimulus(input bit bv, input logic [31:0] bpc, input bit rv, input bit rt,
                                 input bit fl, input bit lv, input logic [31:0] lpc);
        logic [9:0] idx;
        @(negedge clock);
        br_valid = bv; br_pc = bpc; res_valid = rv; res_taken = rt;
        flush = fl; lk_valid = lv; lk_pc = lpc;
        #1;
        if (tb_run) begin
            checkOutput("br_ready", br_ready, ref_q.size() < 4);
            checkOutput("err", err, ref_err);
            checkOutput("res_ready_on_empty", res_ready && (ref_q.size() == 0), 0);
            if (lv && !lk_stall) checkOutput("lk_hist", lk_hist, ref_hist[lpc[9:0]]);
            if (rv && ref_q.size() == 0) ref_err = 1'b1;
            if (rv && res_ready && ref_q.size() > 0) begin
                idx = ref_q.pop_front();
                ref_hist[idx] = {rt, ref_hist[idx][9:1]};
            end
            if (fl) ref_q.delete();
            else if (bv && br_ready) ref_q.push_back(bpc[9:0]);
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int nonzero;
        bit bv, rv, fl, lv;
        logic [31:0] bpc, lpc;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 10'($urandom) | 10'd1;
            ref_hist[i] = '0;
        end

        // Outputs held at zero while reset is asserted
        lk_valid = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("reset_outs", {tbl_we, lk_stall, init_done, br_ready, res_ready, err, tbl_waddr}, 0);

        // Table clear sweep after reset release
        reset = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            #1;
            checkOutput("init_sweep", {tbl_we, lk_stall, init_done, br_ready, tbl_waddr, tbl_wdata},
                        {1'b1, 1'b1, 1'b0, 1'b0, 10'(k), 10'd0});
            @(negedge clock);
        end
        #1;
        checkOutput("init_done", {init_done, br_ready, tbl_we, lk_stall}, 4'b1100);
        nonzero = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== 10'd0) nonzero++;
        checkOutput("init_cleared", nonzero, 0);
        lk_valid = 1'b0;
        tb_run = 1'b1;

        // Simple update: push 1234 (idx 210), resolve taken, write next cycle
        applyStimulus(1, 1234, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("t2_res_ready", res_ready, 1);
        checkOutput("t2_no_early_write", tbl_we, 0);
        idle();
        checkOutput("t2_write", {tbl_we, tbl_waddr, tbl_wdata}, {1'b1, 10'd210, 10'h200});

        // Shared read with bypass of the post-update value
        applyStimulus(1, 1234, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1234);
        checkOutput("t3_lk_hist", lk_hist, 10'h300);
        checkOutput("t3_lk_stall", lk_stall, 0);
        checkOutput("t3_write", {tbl_we, tbl_waddr, tbl_wdata}, {1'b1, 10'd210, 10'h300});

        // Starvation: lookup on idx 7 blocks pending idx 5 for 8 cycles
        applyStimulus(1, 5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 7);
            if (c < 9) begin
                checkOutput("t4_blocked", {lk_stall, tbl_we}, 2'b00);
            end else begin
                checkOutput("t4_steal", {lk_stall, tbl_we, tbl_waddr}, {1'b1, 1'b1, 10'd5});
                checkOutput("t4_steal_hist", lk_hist, 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 7);
        checkOutput("t4_after", {lk_stall, tbl_we}, 2'b00);

        // Fill, then flush with a push attempt
        for (int i = 0; i < 4; i++) applyStimulus(1, 100 + i, 0, 0, 0, 0, 0);
        applyStimulus(1, 200, 0, 0, 1, 0, 0);
        checkOutput("t5_full", br_ready, 0);
        idle();
        checkOutput("t5_flushed", {br_ready, res_ready}, 2'b10);
        applyStimulus(1, 300, 0, 0, 0, 0, 0);
        applyStimulus(1, 301, 0, 0, 1, 0, 0);
        idle();
        checkOutput("t5_push_dropped", res_ready, 0);

        // Flush together with a resolution: the head still resolves
        applyStimulus(1, 20, 0, 0, 0, 0, 0);
        applyStimulus(1, 21, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        checkOutput("t5_res_with_flush", res_ready, 1);
        idle();
        checkOutput("t5_flush_write", {tbl_we, tbl_waddr, tbl_wdata}, {1'b1, 10'd20, 10'h200});
        checkOutput("t5_flush_empty", res_ready, 0);

        // Random traffic on a small set of indices to provoke collisions
        for (int n = 0; n < 800; n++) begin
            bv  = ($urandom_range(0, 1) == 1);
            bpc = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7);
            rv  = (ref_q.size() > 0) && ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 99) < 3);
            lv  = (n >= 400 && n < 500) ? 1'b1 : ($urandom_range(0, 9) < 6);
            lpc = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 7);
            applyStimulus(bv, bpc, rv, 1'($urandom), fl, lv, lpc);
        end

        // Drain everything in flight, then compare the whole table
        for (int n = 0; n < 40; n++) begin
            applyStimulus(0, 0, ref_q.size() > 0, 1'($urandom), 0, 0, 0);
        end
        repeat (3) idle();
        checkOutput("drain_empty", ref_q.size(), 0);
        nonzero = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_hist[i]) nonzero++;
        checkOutput("table_contents", nonzero, 0);

        // Resolution with nothing in flight sets the sticky error
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("t6_no_write", {tbl_we, res_ready}, 2'b00);
        idle();
        checkOutput("t6_err", {err, tbl_we}, 2'b10);
        idle();
        checkOutput("t6_err_sticky", err, 1);

        // Reset pulse, then a second reset part-way through the clear sweep
        @(negedge clock);
        reset = 1'b0; tb_run = 1'b0; ref_q.delete(); ref_err = 1'b0;
        lk_valid = 1'b0; res_valid = 1'b0; br_valid = 1'b0; flush = 1'b0;
        #1;
        checkOutput("rst2_outs", {tbl_we, init_done, br_ready, err, lk_stall}, 0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 300; k++) begin
            #1;
            checkOutput("reinit_sweep", {tbl_we, tbl_waddr}, {1'b1, 10'(k)});
            @(negedge clock);
        end
        #1;
        checkOutput("reinit_at_300", tbl_waddr, 300);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midinit_reset", {tbl_we, tbl_waddr, err}, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("restart_0", {tbl_we, tbl_waddr}, {1'b1, 10'd0});
        @(negedge clock);
        #1;
        checkOutput("restart_1", {tbl_we, tbl_waddr}, {1'b1, 10'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
